// File: rtl/if_fetch_queue.sv
// ============================================================================
// Module   : if_fetch_queue
// Brief    : Sequential instruction fetch from a 1-cycle IRAM into a prefetch
//            queue, handed to ID with valid/ready; trap > xret > jump redirects.
//            Optional performance counters are built when IF_PERF_CNT_EN is defined.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module if_fetch_queue #(
    parameter int          IWIDTH   = 12,
    parameter int          QDEPTH   = 4,
    parameter logic [29:0] RESET_PC = 30'h0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cpu_start,
    input  logic [29:0]       start_adr,
    input  logic              trap_req,
    input  logic [29:0]       trap_adr,
    input  logic              xret_req,
    input  logic [29:0]       xret_adr,
    input  logic              jmp_req,
    input  logic [29:0]       jmp_adr,
    output logic              post_redirect,
    output logic              id_valid,
    input  logic              id_ready,
    output logic [31:0]       inst_id,
    output logic [29:0]       pc_id,
    output logic [IWIDTH-1:0] iram_radr,
    input  logic [31:0]       iram_rdata,
    input  logic              i_read_sel,
    input  logic [IWIDTH-1:0] i_ram_radr,
    output logic [31:0]       perf_fetch,
    output logic [31:0]       perf_bubble
);

    localparam int              c_PW    = $clog2(QDEPTH);
    localparam logic [c_PW+1:0] c_DEPTH = (c_PW+2)'(QDEPTH);
    localparam logic [31:0]     c_NOP   = 32'h0000_0013;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_MON  = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [29:0]       pc_fetch_q, pc_fetch_d;
    logic [29:0]       qpc_q   [QDEPTH];
    logic [31:0]       qinst_q [QDEPTH];
    logic [c_PW-1:0]   rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
    logic [c_PW:0]     count_q, count_d;
    logic              inflight_q, inflight_d;
    logic [29:0]       inflight_pc_q, inflight_pc_d;
    logic              post_trap_q;
    logic              post_redirect_q, post_redirect_d;

    logic              accept, redirect, flush, issue, push, pop;
    logic [29:0]       redirect_adr;
    logic [c_PW+1:0]   occupancy;

    always_comb begin
        accept       = trap_req | ((xret_req | jmp_req) & ~post_trap_q);
        redirect     = accept & (state_q != S_IDLE);
        redirect_adr = trap_req ? trap_adr : (xret_req ? xret_adr : jmp_adr);
        flush        = cpu_start | redirect;
        // Reserve a slot for every read in flight so a response always has room.
        occupancy    = (c_PW+2)'(count_q) + (c_PW+2)'(inflight_q);
        issue        = (state_q == S_RUN) & ~i_read_sel & (occupancy < c_DEPTH);
        push         = inflight_q & ~flush;
        pop          = (count_q != '0) & id_ready & ~flush;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  state_d = S_IDLE;
            S_RUN:   if (i_read_sel)  state_d = S_MON;
            S_MON:   if (!i_read_sel) state_d = S_RUN;
            default: state_d = S_IDLE;
        endcase
        if (cpu_start) state_d = S_RUN;
    end

    always_comb begin
        pc_fetch_d      = pc_fetch_q;
        inflight_d      = issue & ~flush;
        inflight_pc_d   = pc_fetch_q;
        count_d         = count_q + (c_PW+1)'(push) - (c_PW+1)'(pop);
        wr_ptr_d        = wr_ptr_q + c_PW'(push);
        rd_ptr_d        = rd_ptr_q + c_PW'(pop);
        post_redirect_d = redirect & ~cpu_start;
        if (cpu_start) begin
            pc_fetch_d = start_adr;
        end else if (redirect) begin
            pc_fetch_d = redirect_adr;
        end else if (issue) begin
            pc_fetch_d = pc_fetch_q + 30'd1;
        end
        if (flush) begin
            count_d  = '0;
            wr_ptr_d = '0;
            rd_ptr_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q         <= S_IDLE;
            pc_fetch_q      <= RESET_PC;
            rd_ptr_q        <= '0;
            wr_ptr_q        <= '0;
            count_q         <= '0;
            inflight_q      <= 1'b0;
            inflight_pc_q   <= '0;
            post_trap_q     <= 1'b0;
            post_redirect_q <= 1'b0;
        end else begin
            state_q         <= state_d;
            pc_fetch_q      <= pc_fetch_d;
            rd_ptr_q        <= rd_ptr_d;
            wr_ptr_q        <= wr_ptr_d;
            count_q         <= count_d;
            inflight_q      <= inflight_d;
            inflight_pc_q   <= inflight_pc_d;
            post_trap_q     <= trap_req;
            post_redirect_q <= post_redirect_d;
        end
    end

    // Entry storage needs no reset: the empty-queue output mux hides it.
    always_ff @(posedge clk) begin
        if (push) begin
            qpc_q[wr_ptr_q]   <= inflight_pc_q;
            qinst_q[wr_ptr_q] <= iram_rdata;
        end
    end

    assign post_redirect = post_redirect_q;
    assign id_valid      = (count_q != '0);
    assign inst_id       = id_valid ? qinst_q[rd_ptr_q] : c_NOP;
    assign pc_id         = id_valid ? qpc_q[rd_ptr_q] : 30'h0;
    assign iram_radr     = i_read_sel ? i_ram_radr : pc_fetch_q[IWIDTH-1:0];

`ifdef IF_PERF_CNT_EN
    logic [31:0] perf_fetch_q, perf_bubble_q;

    always_ff @(posedge clk) begin
        if (rst || cpu_start) begin
            perf_fetch_q  <= '0;
            perf_bubble_q <= '0;
        end else begin
            if (pop) perf_fetch_q <= perf_fetch_q + 32'd1;
            if ((state_q == S_RUN) && !id_valid) perf_bubble_q <= perf_bubble_q + 32'd1;
        end
    end

    assign perf_fetch  = perf_fetch_q;
    assign perf_bubble = perf_bubble_q;
`else
    assign perf_fetch  = 32'd0;
    assign perf_bubble = 32'd0;
`endif

endmodule

`default_nettype wire
